pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three events: load-use hazards, taken branches/jumps resolved in EX, and data-memory wait states. A small FSM holds the pipeline frozen during memory waits and stretches branch flushes to cover fetch latency. A sticky timeout flag reports a memory wait that lasts too long.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_load_use.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and widths for the pipeline hazard controller
// Purpose: FSM state encodings, state width and register-index width used by
//          pipe_hazard_ctrl and load_use_detect.
package pipe_ctrl_pkg;

    localparam int STATE_W   = 2;
    localparam int REG_IDX_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// rtl/pipe_hazard_ctrl_load_use.sv - combinational load-use hazard comparator
// Purpose: flags an ID instruction that reads the destination of a load in EX.
// Ports:
//   i_id_rs1, i_id_rs2         : ID source register indices
//   i_id_use_rs1, i_id_use_rs2 : ID instruction really reads that source
//   i_ex_rd                    : EX destination register index
//   i_ex_mem_read              : EX instruction is a load
//   o_load_use                 : hazard present this cycle
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_use_rs1,
    input  logic                 i_id_use_rs2,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_ex_mem_read,
    output logic                 o_load_use
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_hit_rs2  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign o_load_use = i_ex_mem_read && (i_ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Purpose: drives stage-register enables and flushes from load-use hazards,
//          EX-resolved redirects and data-memory wait states.
// Optional feature macro: PIPE_CTRL_PERF_EN (adds stall_cycles / flush_events).
// Ports:
//   clk, reset (sync, active-low)
//   id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read : hazard inputs
//   ex_branch_taken : EX redirects the PC this cycle
//   mem_busy        : data memory not ready
//   pc_en, if_id_en, id_ex_en, ex_mem_en : stage-register load enables
//   if_id_flush, id_ex_flush, mem_wb_bubble : bubble controls
//   state           : current FSM state (debug)
//   mem_timeout     : sticky over-long memory wait flag
//   stall_cycles, flush_events : perf counters (PIPE_CTRL_PERF_EN only)
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 mem_busy,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_wb_bubble,
    output logic [STATE_W-1:0]   state,
    output logic                 mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_events
`endif
);

    localparam int                WCNT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX    = WCNT_W'(MEM_TIMEOUT);
    localparam logic [3:0]        FCNT_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t              r_state;
    state_t              r_ret_state;
    logic [3:0]          r_fcnt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_mem_timeout;

    state_t              w_eff_state;
    state_t              w_state_nxt;
    state_t              w_ret_nxt;
    logic [3:0]          w_fcnt_nxt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic                w_load_use;
    logic                w_redirect;
    logic                w_pc_en;
    logic                w_if_id_en;
    logic                w_id_ex_en;
    logic                w_ex_mem_en;
    logic                w_if_id_flush;
    logic                w_id_ex_flush;
    logic                w_mem_wb_bubble;

    load_use_detect u_load_use (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_use_rs1  (id_use_rs1),
        .i_id_use_rs2  (id_use_rs2),
        .i_ex_rd       (ex_rd),
        .i_ex_mem_read (ex_mem_read),
        .o_load_use    (w_load_use)
    );

    // MEM_WAIT behaves as the state it interrupted once memory is ready, so a
    // branch or flush frozen during the wait resumes in the same cycle.
    always_comb begin
        case (r_state)
            ST_FLUSH:    w_eff_state = ST_FLUSH;
            ST_MEM_WAIT: w_eff_state = r_ret_state;
            default:     w_eff_state = ST_RUN;
        endcase
    end

    always_comb begin
        w_pc_en         = 1'b1;
        w_if_id_en      = 1'b1;
        w_id_ex_en      = 1'b1;
        w_ex_mem_en     = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_mem_wb_bubble = 1'b0;
        w_redirect      = 1'b0;
        w_state_nxt     = ST_RUN;
        w_ret_nxt       = r_ret_state;
        w_fcnt_nxt      = r_fcnt;
        w_wcnt_nxt      = '0;

        if (mem_busy) begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_en     = 1'b0;
            w_mem_wb_bubble = 1'b1;
            w_state_nxt     = ST_MEM_WAIT;
            w_ret_nxt       = w_eff_state;
            w_wcnt_nxt      = (r_wcnt == WCNT_MAX) ? r_wcnt : r_wcnt + 1'b1;
        end else if (ex_branch_taken) begin
            // Redirect from RUN or FLUSH; in FLUSH this restarts the stretch.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_redirect    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = ST_FLUSH;
                w_fcnt_nxt  = FCNT_RELOAD;
            end else begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = '0;
            end
        end else if (w_eff_state == ST_FLUSH) begin
            // Extra fetch bubbles; load-use is moot since ID holds a bubble.
            w_if_id_flush = 1'b1;
            w_fcnt_nxt    = r_fcnt - 4'd1;
            w_state_nxt   = (r_fcnt == 4'd1) ? ST_RUN : ST_FLUSH;
        end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_ret_state   <= ST_RUN;
            r_fcnt        <= '0;
            r_wcnt        <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_wcnt      <= w_wcnt_nxt;
            if (mem_busy && (w_wcnt_nxt == WCNT_MAX)) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign pc_en         = reset & w_pc_en;
    assign if_id_en      = reset & w_if_id_en;
    assign id_ex_en      = reset & w_id_ex_en;
    assign ex_mem_en     = reset & w_ex_mem_en;
    assign if_id_flush   = reset & w_if_id_flush;
    assign id_ex_flush   = reset & w_id_ex_flush;
    assign mem_wb_bubble = reset & w_mem_wb_bubble;
    assign state         = reset ? STATE_W'(r_state) : '0;
    assign mem_timeout   = reset & r_mem_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_pc_en) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_redirect) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy;

    logic       pc_en[2], if_id_en[2], id_ex_en[2], ex_mem_en[2];
    logic       if_id_flush[2], id_ex_flush[2], mem_wb_bubble[2], mem_timeout[2];
    logic [1:0] state[2];
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles[2], flush_events[2];
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(3)) dut0 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .id_ex_en(id_ex_en[0]), .ex_mem_en(ex_mem_en[0]),
        .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]), .mem_wb_bubble(mem_wb_bubble[0]),
        .state(state[0]), .mem_timeout(mem_timeout[0])
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(stall_cycles[0]), .flush_events(flush_events[0])
`endif
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(5)) dut1 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .id_ex_en(id_ex_en[1]), .ex_mem_en(ex_mem_en[1]),
        .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]), .mem_wb_bubble(mem_wb_bubble[1]),
        .state(state[1]), .mem_timeout(mem_timeout[1])
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(stall_cycles[1]), .flush_events(flush_events[1])
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of each instance: pending fetch bubbles after a redirect, length of
    // the current busy run, whether the previous cycle was busy, sticky timeout.
    int          fc[2] = '{3, 1};
    int          mt[2] = '{3, 5};
    int          bubbles[2];
    int          busy_run[2];
    bit          prev_busy[2];
    bit          tmo[2];
    int unsigned m_stall[2];
    int unsigned m_fev[2];
    logic [9:0]  exp_o[2];
    logic [9:0]  last_act[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, state[1:0], mem_timeout}
    function automatic logic [9:0] act_vec(int k);
        return {pc_en[k], if_id_en[k], id_ex_en[k], ex_mem_en[k], if_id_flush[k],
                id_ex_flush[k], mem_wb_bubble[k], state[k], mem_timeout[k]};
    endfunction

    function automatic bit hazard();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [9:0] model_out(int k);
        logic [1:0] st;
        st = prev_busy[k] ? 2'd2 : ((bubbles[k] > 0) ? 2'd1 : 2'd0);
        if (!reset)           return 10'd0;
        if (mem_busy)         return {4'b0000, 3'b001, st, tmo[k]};
        if (ex_branch_taken)  return {4'b1111, 3'b110, st, tmo[k]};
        if (bubbles[k] > 0)   return {4'b1111, 3'b100, st, tmo[k]};
        if (hazard())         return {4'b0011, 3'b010, st, tmo[k]};
        return {4'b1111, 3'b000, st, tmo[k]};
    endfunction

    task automatic model_commit(input int k, input logic [9:0] o);
        if (!reset) begin
            bubbles[k] = 0; busy_run[k] = 0; prev_busy[k] = 0; tmo[k] = 0;
            m_stall[k] = 0; m_fev[k] = 0;
        end else begin
            if (!o[9]) m_stall[k]++;
            if (mem_busy) begin
                prev_busy[k] = 1;
                if (busy_run[k] < mt[k]) busy_run[k]++;
                if (busy_run[k] >= mt[k]) tmo[k] = 1;
            end else begin
                prev_busy[k] = 0;
                busy_run[k]  = 0;
                if (ex_branch_taken) begin
                    bubbles[k] = fc[k] - 1;
                    m_fev[k]++;
                end else if (bubbles[k] > 0) begin
                    bubbles[k]--;
                end
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_o[k]    = model_out(k);
            last_act[k] = act_vec(k);
            chk($sformatf("dut%0d_outputs", k), {22'd0, last_act[k]}, {22'd0, exp_o[k]});
`ifdef PIPE_CTRL_PERF_EN
            chk($sformatf("dut%0d_stall_cycles", k), stall_cycles[k], m_stall[k]);
            chk($sformatf("dut%0d_flush_events", k), flush_events[k], m_fev[k]);
`endif
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_commit(k, exp_o[k]);
        #1;
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic busy);
        reset = rst; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br; mem_busy = busy;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("reset_outputs_zero", {22'd0, last_act[0]}, 32'd0);
        idle();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_reset();

        // Idle after reset: everything enabled, no flush.
        cycle();
        chk("idle_after_reset", {22'd0, last_act[0]}, {22'd0, 10'b1111_000_00_0});

        // Load-use stall for one cycle, then free-running.
        drive(1, 5, 1, 0, 0, 5, 1, 0, 0);
        cycle();
        chk("lu_pc_en", last_act[0][9], 0);
        chk("lu_if_id_en", last_act[0][8], 0);
        chk("lu_id_ex_flush", last_act[0][4], 1);
        idle();
        cycle();
        chk("lu_next_enables", last_act[0][9:6], 4'b1111);

        // Load to x0 is never a hazard.
        drive(1, 0, 0, 0, 1, 0, 1, 0, 0);
        cycle();
        chk("x0_no_stall", last_act[0][9:4], 6'b1111_00);

        // Stretched flush (dut0: 3 cycles) vs single flush (dut1).
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        chk("br_c0_flushes", last_act[0][5:4], 2'b11);
        chk("br_c0_state", last_act[0][2:1], 0);
        idle();
        cycle();
        chk("br_c1_flushes", last_act[0][5:4], 2'b10);
        chk("br_c1_state", last_act[0][2:1], 1);
        chk("br1_c1_no_flush", last_act[1][5], 0);
        cycle();
        chk("br_c2_flushes", last_act[0][5:4], 2'b10);
        chk("br_c2_state", last_act[0][2:1], 1);
        cycle();
        chk("br_c3_flushes", last_act[0][5:4], 2'b00);
        chk("br_c3_state", last_act[0][2:1], 0);

        // Busy with a pending branch: 4 frozen cycles, redirect on the 5th.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
            cycle();
            chk("busy_freeze", last_act[0][9:3], 7'b0000_001);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        chk("busy_exit_redirect", last_act[0][9:3], 7'b1111_110);
        chk("busy_exit_state", last_act[0][2:1], 2);
        idle();
        cycle();
        cycle();

        // Timeout: dut0 tolerates 3 busy cycles, dut1 tolerates 5.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
            cycle();
            chk("tmo_during_busy", last_act[0][0], (i > 3) ? 1 : 0);
        end
        idle();
        cycle();
        chk("tmo_sticky0", last_act[0][0], 1);
        chk("tmo_sticky1", last_act[1][0], 1);
        cycle();
        chk("tmo_still_set", last_act[0][0], 1);

        // Reset during FLUSH abandons the redirect.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        idle();
        cycle();
        chk("midflush_state", last_act[0][2:1], 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("midflush_reset_out", {22'd0, last_act[0]}, 32'd0);
        cycle();
        chk("midflush_reset_out2", {22'd0, last_act[0]}, 32'd0);
        idle();
        cycle();
        chk("midflush_release", last_act[0][9:1], 9'b1111_000_00);

        // Random traffic checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                  5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
